// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and watchdog width.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_REL  = 2'd2
    } state_t;

    localparam int c_WDOG_W = 10;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module uart_tx_arbiter_rr_pick #(
    parameter int c_N = 4
) (
    input  logic [c_N-1:0]         req,
    input  logic [$clog2(c_N)-1:0] ptr,
    output logic [c_N-1:0]         grant,
    output logic [$clog2(c_N)-1:0] idx,
    output logic                   any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 1; i <= c_N; i++) begin
            j = (int'(ptr) + i) % c_N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = $clog2(c_N)'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART transmitter byte port, with packet lock
// and a sticky watchdog on the enable/busy handshake.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int c_NREQ    = 4,
    parameter int c_TIMEOUT = 1023
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [c_NREQ-1:0]     i_req,
    input  logic [c_NREQ-1:0]     i_last,
    input  logic [8*c_NREQ-1:0]   i_data,
    output logic [c_NREQ-1:0]     o_ack,
    output logic [c_NREQ-1:0]     o_grant,
    output logic [7:0]            o_data,
    output logic                  o_enable,
    input  logic                  i_busy,
    output logic                  o_timeout,
    output state_t                o_state
);

    localparam int c_IW = $clog2(c_NREQ);

    // Handshake: o_enable rises with o_data/o_grant valid and holds them until
    // busy is seen; o_enable then drops, and the next byte waits for busy to fall.
    state_t                state_q, state_d;
    logic                  lock_q, lock_d;
    logic [c_IW-1:0]       ptr_q, ptr_d;
    logic [c_WDOG_W-1:0]   cnt_q, cnt_d;
    logic                  busy_q;
    logic [c_NREQ-1:0]     ack_d, grant_d;
    logic [7:0]            data_d;
    logic                  enable_d, timeout_d;

    logic [7:0]            data_arr [c_NREQ];
    logic [c_NREQ-1:0]     pick_grant;
    logic [c_IW-1:0]       pick_idx;
    logic                  pick_any;

    for (genvar k = 0; k < c_NREQ; k++) begin : g_data
        assign data_arr[k] = i_data[8*k +: 8];
    end

    uart_tx_arbiter_rr_pick #(.c_N(c_NREQ)) u_pick (
        .req   (i_req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_d   = o_grant;
        data_d    = o_data;
        enable_d  = o_enable;
        timeout_d = o_timeout;
        ack_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d  = pick_grant;
                    data_d   = data_arr[pick_idx];
                    enable_d = 1'b1;
                    lock_d   = 1'b1;
                    ptr_d    = pick_idx;
                    cnt_d    = '0;
                    state_d  = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (busy_q) begin
                    enable_d = 1'b0;
                    ack_d    = o_grant;
                    lock_d   = lock_q & ~i_last[ptr_q];
                    state_d  = ST_WAIT_REL;
                end else if (cnt_q == c_WDOG_W'(c_TIMEOUT - 1)) begin
                    // Transmitter never answered: the byte is dropped.
                    enable_d  = 1'b0;
                    timeout_d = 1'b1;
                    lock_d    = 1'b0;
                    state_d   = ST_WAIT_REL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_REL: begin
                if (!busy_q) begin
                    if (lock_q && i_req[ptr_q]) begin
                        data_d   = data_arr[ptr_q];
                        enable_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_WAIT_BUSY;
                    end else begin
                        lock_d  = 1'b0;
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            lock_q    <= 1'b0;
            ptr_q     <= c_IW'(c_NREQ - 1);
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            o_ack     <= '0;
            o_grant   <= '0;
            o_data    <= '0;
            o_enable  <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            busy_q    <= i_busy;
            o_ack     <= ack_d;
            o_grant   <= grant_d;
            o_data    <= data_d;
            o_enable  <= enable_d;
            o_timeout <= timeout_d;
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter busy model.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, last;
    logic [31:0] data;
    logic        busy = 1'b0;
    logic [3:0]  ack, grant;
    logic [7:0]  odata;
    logic        enable, timeout;
    state_t      st;

    int          vectors = 0;
    int          miscompares = 0;

    logic        busy_dead;
    int          hold_len;
    int          hold_cnt = 0;
    int          en_cnt = 0;
    int          dis_cnt = 0;
    logic [7:0]  tx_q [$];

    logic [3:0]  who;
    int          cyc;

    uart_tx_arbiter #(.c_NREQ(4), .c_TIMEOUT(1023)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_req     (req),
        .i_last    (last),
        .i_data    (data),
        .o_ack     (ack),
        .o_grant   (grant),
        .o_data    (odata),
        .o_enable  (enable),
        .i_busy    (busy),
        .o_timeout (timeout),
        .o_state   (st)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy rises on the second tick of enable, falls on the
    // second tick after enable drops (plus an optional full-FIFO hold).
    always @(posedge clk) begin
        #2;
        if (!rst_n || busy_dead) begin
            busy = 1'b0; en_cnt = 0; dis_cnt = 0; hold_cnt = 0;
        end else if (!busy && enable) begin
            en_cnt++;
            if (en_cnt == 2) begin
                busy = 1'b1; en_cnt = 0; hold_cnt = hold_len;
                tx_q.push_back(odata);
            end
        end else if (busy && !enable) begin
            if (hold_cnt > 0) hold_cnt--;
            else begin
                dis_cnt++;
                if (dis_cnt == 2) begin busy = 1'b0; dis_cnt = 0; end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_tx(input string tag, input logic [7:0] exp);
        logic [7:0] v;
        v = 8'h00;
        if (tx_q.size() != 0) v = tx_q.pop_front();
        check(tag, 32'(v), 32'(exp));
    endtask

    task automatic wait_ack(input int limit, output logic [3:0] w, output int c);
        w = '0; c = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (ack != 4'b0) begin w = ack; c = i; break; end
        end
        if (c == 0) begin
            vectors++; miscompares++;
            $error("FAIL ack_wait: observed no ack within %0d cycles, expected an ack", limit);
        end
    endtask

    task automatic set_byte(input int k, input logic [7:0] v);
        data[8*k +: 8] = v;
    endtask

    task automatic do_reset();
        req = '0; last = '0; data = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed simulation still running, expected completion");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        logic [3:0] exp_who2 [5];
        logic [7:0] exp_byte2 [5];
        logic [3:0] exp_who3 [4];
        logic [7:0] exp_byte3 [4];
        int en_seen, bad_state, hi_cnt;
        logic ack_seen;

        exp_who2  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_byte2 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        exp_who3  = '{4'b0001, 4'b0001, 4'b0001, 4'b0100};
        exp_byte3 = '{8'h10, 8'h11, 8'h12, 8'h22};

        rst_n = 1'b0; req = '0; last = '0; data = '0;
        busy_dead = 1'b0; hold_len = 0;

        // Reset values
        #3;
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_data", 32'(odata), 32'h0);
        check("rst_enable", 32'(enable), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        check("rst_state", 32'(st), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte from requester 0
        req = 4'b0001; last = 4'b0001; set_byte(0, 8'h41);
        @(negedge clk);
        check("t1_enable", 32'(enable), 32'h1);
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_data", 32'(odata), 32'h41);
        wait_ack(20, who, cyc);
        check("t1_ack_who", 32'(who), 32'h1);
        check("t1_ack_lat", 32'(cyc), 32'd3);
        check("t1_en_low_at_ack", 32'(enable), 32'h0);
        req = '0;
        @(negedge clk);
        check("t1_ack_pulse", 32'(ack), 32'h0);
        check_tx("t1_tx", 8'h41);
        repeat (8) @(negedge clk);
        check("t1_idle", 32'(st), 32'(ST_IDLE));
        check("t1_grant_idle", 32'(grant), 32'h0);
        check("t1_no_timeout", 32'(timeout), 32'h0);

        // Contention: all four requesters, then requester 0 again
        do_reset();
        req = 4'b1111; last = 4'b1111;
        set_byte(0, 8'hA0); set_byte(1, 8'hA1); set_byte(2, 8'hA2); set_byte(3, 8'hA3);
        for (int i = 0; i < 5; i++) begin
            wait_ack(40, who, cyc);
            check($sformatf("t2_who%0d", i), 32'(who), 32'(exp_who2[i]));
            check_tx($sformatf("t2_tx%0d", i), exp_byte2[i]);
            if (i == 0) set_byte(0, 8'hA4);
            else req = req & ~who;
        end
        repeat (8) @(negedge clk);
        check("t2_idle", 32'(st), 32'(ST_IDLE));

        // Packet lock: requester 0 sends 3 bytes while requester 2 waits
        req = 4'b0001; last = 4'b0000; set_byte(0, 8'h10);
        @(negedge clk);
        req[2] = 1'b1; last[2] = 1'b1; set_byte(2, 8'h22);
        for (int i = 0; i < 4; i++) begin
            wait_ack(40, who, cyc);
            check($sformatf("t3_who%0d", i), 32'(who), 32'(exp_who3[i]));
            check_tx($sformatf("t3_tx%0d", i), exp_byte3[i]);
            if (i == 0) set_byte(0, 8'h11);
            else if (i == 1) begin set_byte(0, 8'h12); last[0] = 1'b1; end
            else if (i == 2) req[0] = 1'b0;
            else req[2] = 1'b0;
        end
        repeat (8) @(negedge clk);

        // Full FIFO: busy stays high ~1000 cycles after the accept
        hold_len = 1000;
        req = 4'b0010; last = 4'b0010; set_byte(1, 8'h31);
        wait_ack(20, who, cyc);
        check("t4_who", 32'(who), 32'h2);
        check_tx("t4_tx", 8'h31);
        hold_len = 0;
        req = 4'b1000; last[3] = 1'b1; set_byte(3, 8'h33);
        en_seen = 0; bad_state = 0;
        for (int i = 0; i < 990; i++) begin
            @(negedge clk);
            if (enable) en_seen++;
            if (st != ST_WAIT_REL) bad_state++;
        end
        check("t4_no_enable", 32'(en_seen), 32'd0);
        check("t4_stay_rel", 32'(bad_state), 32'd0);
        check("t4_no_timeout", 32'(timeout), 32'h0);
        wait_ack(60, who, cyc);
        check("t4_resume_who", 32'(who), 32'h8);
        check_tx("t4_resume_tx", 8'h33);
        req = '0;
        repeat (8) @(negedge clk);

        // Watchdog: busy never rises
        busy_dead = 1'b1;
        req = 4'b0001; last = 4'b0001; set_byte(0, 8'h55);
        @(negedge clk);
        check("t5_enable", 32'(enable), 32'h1);
        hi_cnt = 1; ack_seen = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (ack != 4'b0) ack_seen = 1'b1;
            if (!enable) break;
            hi_cnt++;
        end
        check("t5_enable_cycles", 32'(hi_cnt), 32'd1023);
        check("t5_timeout", 32'(timeout), 32'h1);
        check("t5_no_ack", 32'(ack_seen), 32'h0);
        busy_dead = 1'b0;
        wait_ack(20, who, cyc);
        check("t5_rearb_who", 32'(who), 32'h1);
        check_tx("t5_rearb_tx", 8'h55);
        check("t5_timeout_sticky", 32'(timeout), 32'h1);
        req = '0;
        repeat (8) @(negedge clk);

        // Reset mid-packet, then requester 0 wins first
        req = 4'b0010; last = 4'b0011; set_byte(1, 8'h61); set_byte(0, 8'h60);
        @(negedge clk);
        check("t6_enable", 32'(enable), 32'h1);
        check("t6_grant", 32'(grant), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_enable", 32'(enable), 32'h0);
        check("t6_rst_grant", 32'(grant), 32'h0);
        check("t6_rst_data", 32'(odata), 32'h0);
        check("t6_rst_timeout", 32'(timeout), 32'h0);
        check("t6_rst_state", 32'(st), 32'(ST_IDLE));
        @(negedge clk);
        req = 4'b0011;
        rst_n = 1'b1;
        wait_ack(20, who, cyc);
        check("t6_first_who", 32'(who), 32'h1);
        check_tx("t6_first_tx", 8'h60);
        req[0] = 1'b0;
        wait_ack(40, who, cyc);
        check("t6_second_who", 32'(who), 32'h2);
        check_tx("t6_second_tx", 8'h61);
        req = '0;
        repeat (8) @(negedge clk);
        check("t6_tx_drained", 32'(tx_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
